// File: rtl/mips_ex_stage_pkg.sv
// ============================================================================
// mips_pkg: opcodes, opcode classes, execute-stage FSM states, classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, UNDEF
  } op_class_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic op_class_e op_classify(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: op_classify = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     op_classify = RM_ALU;
      OP_LW:                                         op_classify = LOAD;
      OP_SW:                                         op_classify = STORE;
      OP_BNEQZ, OP_BEQZ:                             op_classify = BRANCH;
      OP_HLT:                                        op_classify = HALT;
      default:                                       op_classify = UNDEF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ex_stage_iter_mul.sv
// ============================================================================
// mips_iter_mul: iterative shift-add multiplier, MUL_STEP bits per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_iter_mul #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int PROD_W   = XLEN
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p
);

  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] partial;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // done is high during the cycle whose edge retires the final step,
  // so p holds the complete product from the following cycle onward.
  assign done = busy_q && (cnt_q == LAST_STEP);
  assign busy = busy_q;
  assign p    = acc_q;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = PROD_W'(a);
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_ex_stage.sv
// ============================================================================
// mips_ex_stage: MIPS32 execute stage with valid/ready handshakes, iterative
// MUL, branch resolution and sticky halt. Optional macro MIPS_EX_OVF_EN adds
// the ovf output. Rev 1.0
// ============================================================================
`default_nettype none

module mips_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 26,
  parameter int MUL_STEP = 1
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_npc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic [XLEN-1:0]  out_result,
  output logic [XLEN-1:0]  out_b,
  output logic             out_cond,
  output logic [TAG_W-1:0] out_tag,
  output logic             halted
`ifdef MIPS_EX_OVF_EN
  ,
  output logic             ovf
`endif
);

`ifdef MIPS_EX_OVF_EN
  localparam int PROD_W = 2 * XLEN;
`else
  localparam int PROD_W = XLEN;
`endif

  state_e            state_q, state_d;
  logic              halted_q, halted_d;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        out_opcode_q, out_opcode_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [XLEN-1:0]   out_b_q, out_b_d;
  logic              out_cond_q, out_cond_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [XLEN-1:0]   pend_b_q, pend_b_d;
  logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;

  op_class_e         in_class;
  logic              accept, is_mul, out_free, load_single, load_mul;
  logic [XLEN-1:0]   add_ab, sub_ab, add_ai, sub_ai;
  logic              slt_ab, slt_ai;
  logic [XLEN-1:0]   alu_result;
  logic              alu_cond;
  logic              mul_busy, mul_done;
  logic [PROD_W-1:0] mul_p;

  assign in_class = op_classify(in_opcode);
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == S_IDLE) && !mul_busy && !halted_q && out_free;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (in_opcode == OP_MUL);
  assign load_single = accept && !is_mul;
  assign load_mul    = (state_q == S_DONE) && out_free;

  assign add_ab = in_a + in_b;
  assign sub_ab = in_a - in_b;
  assign add_ai = in_a + in_imm;
  assign sub_ai = in_a - in_imm;
  assign slt_ab = $signed(in_a) < $signed(in_b);
  assign slt_ai = $signed(in_a) < $signed(in_imm);

  mips_iter_mul #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP),
    .PROD_W   (PROD_W)
  ) u_mul (
    .clk1  (clk1),
    .reset (reset),
    .start (accept && is_mul),
    .a     (in_a),
    .b     (in_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    alu_result = '0;
    alu_cond   = 1'b0;
    case (in_class)
      RR_ALU: begin
        case (in_opcode)
          OP_ADD:  alu_result = add_ab;
          OP_SUB:  alu_result = sub_ab;
          OP_AND:  alu_result = in_a & in_b;
          OP_OR:   alu_result = in_a | in_b;
          OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, slt_ab};
          default: alu_result = '0;
        endcase
      end
      RM_ALU: begin
        case (in_opcode)
          OP_ADDI: alu_result = add_ai;
          OP_SUBI: alu_result = sub_ai;
          OP_SLTI: alu_result = {{(XLEN-1){1'b0}}, slt_ai};
          default: alu_result = '0;
        endcase
      end
      LOAD, STORE: alu_result = add_ai;
      BRANCH: begin
        alu_result = in_npc + in_imm;
        alu_cond   = (in_opcode == OP_BEQZ) ? (in_a == '0) : (in_a != '0);
      end
      default: alu_result = '0;
    endcase
  end

`ifdef MIPS_EX_OVF_EN
  logic            alu_ovf, mul_ovf, ovf_q, ovf_d;
  logic [XLEN-1:0] pend_a_q, pend_a_d, mul_hi;

  always_comb begin
    case (in_opcode)
      OP_ADD:  alu_ovf = (in_a[XLEN-1] == in_b[XLEN-1]) && (add_ab[XLEN-1] != in_a[XLEN-1]);
      OP_SUB:  alu_ovf = (in_a[XLEN-1] != in_b[XLEN-1]) && (sub_ab[XLEN-1] != in_a[XLEN-1]);
      OP_ADDI: alu_ovf = (in_a[XLEN-1] == in_imm[XLEN-1]) && (add_ai[XLEN-1] != in_a[XLEN-1]);
      OP_SUBI: alu_ovf = (in_a[XLEN-1] != in_imm[XLEN-1]) && (sub_ai[XLEN-1] != in_a[XLEN-1]);
      default: alu_ovf = 1'b0;
    endcase
  end

  // Signed high half = unsigned high half minus each operand where the other is negative.
  assign mul_hi  = mul_p[PROD_W-1:XLEN]
                 - (pend_a_q[XLEN-1] ? pend_b_q : '0)
                 - (pend_b_q[XLEN-1] ? pend_a_q : '0);
  assign mul_ovf = (mul_hi != {XLEN{mul_p[XLEN-1]}});
  assign ovf     = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done) state_d = S_DONE;
      S_DONE:  if (out_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    halted_d     = halted_q || (accept && (in_opcode == OP_HLT));
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_result_d = out_result_q;
    out_b_d      = out_b_q;
    out_cond_d   = out_cond_q;
    out_tag_d    = out_tag_q;
    pend_b_d     = pend_b_q;
    pend_tag_d   = pend_tag_q;
`ifdef MIPS_EX_OVF_EN
    ovf_d        = ovf_q;
    pend_a_d     = pend_a_q;
`endif
    if (accept && is_mul) begin
      pend_b_d   = in_b;
      pend_tag_d = in_tag;
`ifdef MIPS_EX_OVF_EN
      pend_a_d   = in_a;
`endif
    end
    if (load_single) begin
      out_valid_d  = 1'b1;
      out_opcode_d = in_opcode;
      out_result_d = alu_result;
      out_b_d      = in_b;
      out_cond_d   = alu_cond;
      out_tag_d    = in_tag;
`ifdef MIPS_EX_OVF_EN
      ovf_d        = alu_ovf;
`endif
    end else if (load_mul) begin
      out_valid_d  = 1'b1;
      out_opcode_d = OP_MUL;
      out_result_d = mul_p[XLEN-1:0];
      out_b_d      = pend_b_q;
      out_cond_d   = 1'b0;
      out_tag_d    = pend_tag_q;
`ifdef MIPS_EX_OVF_EN
      ovf_d        = mul_ovf;
`endif
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      halted_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_result_q <= '0;
      out_b_q      <= '0;
      out_cond_q   <= 1'b0;
      out_tag_q    <= '0;
      pend_b_q     <= '0;
      pend_tag_q   <= '0;
`ifdef MIPS_EX_OVF_EN
      ovf_q        <= 1'b0;
      pend_a_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_result_q <= out_result_d;
      out_b_q      <= out_b_d;
      out_cond_q   <= out_cond_d;
      out_tag_q    <= out_tag_d;
      pend_b_q     <= pend_b_d;
      pend_tag_q   <= pend_tag_d;
`ifdef MIPS_EX_OVF_EN
      ovf_q        <= ovf_d;
      pend_a_q     <= pend_a_d;
`endif
    end
  end

  assign halted     = halted_q;
  assign out_valid  = out_valid_q;
  assign out_opcode = out_opcode_q;
  assign out_result = out_result_q;
  assign out_b      = out_b_q;
  assign out_cond   = out_cond_q;
  assign out_tag    = out_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_ex_stage.sv
// ============================================================================
// tb_mips_ex_stage: directed, table-driven bench for mips_ex_stage
// (XLEN=32, MUL_STEP=1). Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_ex_stage;

  localparam logic [5:0] T_ADD   = 6'b000000;
  localparam logic [5:0] T_SUB   = 6'b000001;
  localparam logic [5:0] T_AND   = 6'b000010;
  localparam logic [5:0] T_OR    = 6'b000011;
  localparam logic [5:0] T_SLT   = 6'b000100;
  localparam logic [5:0] T_MUL   = 6'b000101;
  localparam logic [5:0] T_LW    = 6'b001000;
  localparam logic [5:0] T_SW    = 6'b001001;
  localparam logic [5:0] T_ADDI  = 6'b001010;
  localparam logic [5:0] T_SUBI  = 6'b001011;
  localparam logic [5:0] T_SLTI  = 6'b001100;
  localparam logic [5:0] T_BNEQZ = 6'b001101;
  localparam logic [5:0] T_BEQZ  = 6'b001110;
  localparam logic [5:0] T_HLT   = 6'b111111;
  localparam logic [5:0] T_UNDEF = 6'b010101;

  logic        clk1 = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_a, in_b, in_imm, in_npc;
  logic [25:0] in_tag;
  logic        out_valid, out_ready;
  logic [5:0]  out_opcode;
  logic [31:0] out_result, out_b;
  logic        out_cond;
  logic [25:0] out_tag;
  logic        halted;
`ifdef MIPS_EX_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  mips_ex_stage #(.XLEN(32), .TAG_W(26), .MUL_STEP(1)) dut (
    .clk1       (clk1),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_imm     (in_imm),
    .in_npc     (in_npc),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_result (out_result),
    .out_b      (out_b),
    .out_cond   (out_cond),
    .out_tag    (out_tag),
    .halted     (halted)
`ifdef MIPS_EX_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, imm, npc;
    logic [31:0] res;
    logic        cond;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, b, imm, npc, input logic [25:0] tag);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_imm    = imm;
    in_npc    = npc;
    in_tag    = tag;
  endtask

  // Called at a negedge with out_valid low; returns at a negedge.
  task automatic run_mul(input logic [31:0] a, b, exp, input logic exp_ovf, input string nm);
    int lo_cnt;
    int hs;
    out_ready = 1'b1;
    drive(T_MUL, a, b, 32'd0, 32'd0, 26'h155);
    check({nm, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk1);
    in_valid = 1'b0;
    lo_cnt = 0;
    hs = 0;
    while (!in_ready && lo_cnt < 100) begin
      if (out_valid && out_ready) hs++;
      lo_cnt++;
      @(negedge clk1);
    end
    check({nm, "_busy_cycles"}, lo_cnt, 33);
    check({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({nm, "_result"}, out_result, exp);
    check({nm, "_opcode"}, {26'd0, out_opcode}, {26'd0, T_MUL});
    check({nm, "_b"}, out_b, b);
    check({nm, "_tag"}, {6'd0, out_tag}, {6'd0, 26'h155});
`ifdef MIPS_EX_OVF_EN
    check({nm, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("unreachable");
`endif
    for (int k = 0; k < 4; k++) begin
      if (out_valid && out_ready) hs++;
      @(negedge clk1);
    end
    check({nm, "_handshakes"}, hs, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs.push_back('{T_ADDI,  32'd10,        32'd0,        32'd20,         32'd0,  32'd30,         1'b0, 1'b0});
    vecs.push_back('{T_ADD,   32'd10,        32'd20,       32'd0,          32'd0,  32'd30,         1'b0, 1'b0});
    vecs.push_back('{T_SUB,   32'd5,         32'd7,        32'd0,          32'd0,  32'hFFFFFFFE,   1'b0, 1'b0});
    vecs.push_back('{T_AND,   32'h0000F0F0,  32'h00000FF0, 32'd0,          32'd0,  32'h000000F0,   1'b0, 1'b0});
    vecs.push_back('{T_OR,    32'h0000F000,  32'h0000000F, 32'd0,          32'd0,  32'h0000F00F,   1'b0, 1'b0});
    vecs.push_back('{T_SLT,   32'hFFFFFFFF,  32'd1,        32'd0,          32'd0,  32'd1,          1'b0, 1'b0});
    vecs.push_back('{T_SLT,   32'd1,         32'hFFFFFFFF, 32'd0,          32'd0,  32'd0,          1'b0, 1'b0});
    vecs.push_back('{T_SLTI,  32'hFFFFFFFB,  32'd0,        32'hFFFFFFFC,   32'd0,  32'd1,          1'b0, 1'b0});
    vecs.push_back('{T_SUBI,  32'd100,       32'd0,        32'd1,          32'd0,  32'd99,         1'b0, 1'b0});
    vecs.push_back('{T_LW,    32'h00000100,  32'd0,        32'hFFFFFFFC,   32'd0,  32'h000000FC,   1'b0, 1'b0});
    vecs.push_back('{T_SW,    32'h00000020,  32'h0000DEAD, 32'd8,          32'd0,  32'h00000028,   1'b0, 1'b0});
    vecs.push_back('{T_BEQZ,  32'd0,         32'd0,        32'hFFFFFFFD,   32'd8,  32'd5,          1'b1, 1'b0});
    vecs.push_back('{T_BNEQZ, 32'd0,         32'd0,        32'hFFFFFFFD,   32'd8,  32'd5,          1'b0, 1'b0});
    vecs.push_back('{T_BNEQZ, 32'd3,         32'd0,        32'd4,          32'd16, 32'd20,         1'b1, 1'b0});
    vecs.push_back('{T_BEQZ,  32'd3,         32'd0,        32'd4,          32'd16, 32'd20,         1'b0, 1'b0});
    vecs.push_back('{T_UNDEF, 32'd1,         32'd2,        32'd3,          32'd4,  32'd0,          1'b0, 1'b0});
    vecs.push_back('{T_ADD,   32'hFFFFFFFF,  32'd1,        32'd0,          32'd0,  32'd0,          1'b0, 1'b0});
    vecs.push_back('{T_ADD,   32'h7FFFFFFF,  32'd1,        32'd0,          32'd0,  32'h80000000,   1'b0, 1'b1});
    vecs.push_back('{T_ADD,   32'd5,         32'd6,        32'd0,          32'd0,  32'd11,         1'b0, 1'b0});
    vecs.push_back('{T_SUB,   32'h80000000,  32'd1,        32'd0,          32'd0,  32'h7FFFFFFF,   1'b0, 1'b1});
    vecs.push_back('{T_ADDI,  32'h7FFFFFFF,  32'd0,        32'd1,          32'd0,  32'h80000000,   1'b0, 1'b1});
    vecs.push_back('{T_AND,   32'h7FFFFFFF,  32'd1,        32'd0,          32'd0,  32'd1,          1'b0, 1'b0});

    reset = 1'b1;
    in_valid = 1'b0;
    in_opcode = '0;
    in_a = '0;
    in_b = '0;
    in_imm = '0;
    in_npc = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    check("rst_out_misc", {out_tag, out_opcode}, 32'd0);
    check("rst_cond_halted", {30'd0, out_cond, halted}, 32'd0);
    reset = 1'b0;
    @(negedge clk1);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // back-to-back single-cycle ops at one per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].npc, 26'(i * 3 + 1));
      check($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk1);
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("tbl%0d_result", i), out_result, vecs[i].res);
      check($sformatf("tbl%0d_cond", i), {31'd0, out_cond}, {31'd0, vecs[i].cond});
      check($sformatf("tbl%0d_opcode", i), {26'd0, out_opcode}, {26'd0, vecs[i].op});
      check($sformatf("tbl%0d_b", i), out_b, vecs[i].b);
      check($sformatf("tbl%0d_tag", i), {6'd0, out_tag}, 32'(i * 3 + 1));
`ifdef MIPS_EX_OVF_EN
      check($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
`endif
    end
    in_valid = 1'b0;
    @(negedge clk1);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    run_mul(32'd7, 32'd6, 32'd42, 1'b0, "mul_7x6");
    run_mul(32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, "mul_m3x5");
    run_mul(32'h00010000, 32'h00010000, 32'd0, 1'b1, "mul_wrap");

    // MUL completing under backpressure
    out_ready = 1'b0;
    drive(T_MUL, 32'd12, 32'd11, 32'd0, 32'd0, 26'h2A);
    @(negedge clk1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      n++;
      @(negedge clk1);
    end
    check("mulbp_latency", n, 33);
    for (int k = 0; k < 3; k++) begin
      check("mulbp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("mulbp_hold_result", out_result, 32'd132);
      check("mulbp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk1);
    end
    out_ready = 1'b1;
    @(negedge clk1);
    check("mulbp_consumed", {31'd0, out_valid}, 32'd0);

    // ADD held under backpressure, next op waits for out_ready
    out_ready = 1'b0;
    drive(T_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 26'h11);
    @(negedge clk1);
    drive(T_SUB, 32'd9, 32'd4, 32'd0, 32'd0, 26'h22);
    for (int k = 0; k < 5; k++) begin
      check("bp_result", out_result, 32'd3);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk1);
    end
    out_ready = 1'b1;
    @(negedge clk1);
    check("bp_next_result", out_result, 32'd5);
    check("bp_next_tag", {6'd0, out_tag}, 32'h22);
    in_valid = 1'b0;
    @(negedge clk1);
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // HLT, then an ADD that must never be accepted
    drive(T_HLT, 32'd5, 32'd6, 32'd7, 32'd8, 26'h33);
    @(negedge clk1);
    check("hlt_halted", {31'd0, halted}, 32'd1);
    check("hlt_valid", {31'd0, out_valid}, 32'd1);
    check("hlt_result", out_result, 32'd0);
    check("hlt_opcode", {26'd0, out_opcode}, {26'd0, T_HLT});
    drive(T_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 26'h44);
    for (int k = 0; k < 6; k++) begin
      check("hlt_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk1);
    end
    check("hlt_sticky", {31'd0, halted}, 32'd1);
    check("hlt_add_dropped", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;

    reset = 1'b1;
    @(negedge clk1);
    reset = 1'b0;
    @(negedge clk1);
    check("unhalt", {31'd0, halted}, 32'd0);

    // reset in the middle of a multiply
    drive(T_MUL, 32'd7, 32'd6, 32'd0, 32'd0, 26'h55);
    @(negedge clk1);
    in_valid = 1'b0;
    repeat (9) @(negedge clk1);
    reset = 1'b1;
    #1;
    check("midmul_rst_valid", {31'd0, out_valid}, 32'd0);
    check("midmul_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk1);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) n++;
      @(negedge clk1);
    end
    check("midmul_no_partial", n, 0);
    check("midmul_in_ready", {31'd0, in_ready}, 32'd1);
    drive(T_ADD, 32'd4, 32'd5, 32'd0, 32'd0, 26'h66);
    @(negedge clk1);
    in_valid = 1'b0;
    check("after_rst_add", out_result, 32'd9);
    check("after_rst_valid", {31'd0, out_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
